// File: rtl/imem_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
// One request strobe per fetch; the response arrives on a later cycle with rvalid.
interface imem_if;
  logic        req;
  logic [31:0] addr;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input rvalid, rdata);
  modport slave  (input req, addr, output rvalid, rdata);
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem fetch, one-entry
// hold buffer for responses that arrive during a stall, and the IF/ID register.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_write,
  input  logic        if_id_write,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  imem_if.master      imem,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr
);

  typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_HOLD, S_DROP} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q, pc_nxt, pc_inc, redirect_tgt;
  logic [31:0] buf_pc, buf_instr;
  logic [31:0] dlv_pc, dlv_instr;
  logic        advance, deliver, buf_load;

  assign advance      = pc_write & if_id_write;
  assign pc_inc       = pc_q + 32'd4;
  assign redirect_tgt = {redirect_pc[31:2], 2'b00};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) state <= S_ISSUE;
    else     state <= state_nxt;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    deliver   = 1'b0;
    buf_load  = 1'b0;
    dlv_pc    = buf_pc;
    dlv_instr = buf_instr;
    case (state)
      S_ISSUE: begin
        if (redirect_valid) pc_nxt = redirect_tgt;
        else                state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem.rvalid && redirect_valid) begin
          pc_nxt    = redirect_tgt;
          state_nxt = S_ISSUE;
        end else if (imem.rvalid && advance) begin
          deliver   = 1'b1;
          dlv_pc    = pc_q;
          dlv_instr = imem.rdata;
          pc_nxt    = pc_inc;
        end else if (imem.rvalid) begin
          buf_load  = 1'b1;
          state_nxt = S_HOLD;
        end else if (redirect_valid) begin
          pc_nxt    = redirect_tgt;
          state_nxt = S_DROP;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_nxt    = redirect_tgt;
          state_nxt = S_ISSUE;
        end else if (advance) begin
          deliver   = 1'b1;
          pc_nxt    = pc_inc;
          state_nxt = S_ISSUE;
        end
      end
      S_DROP: begin
        if (redirect_valid) pc_nxt = redirect_tgt;
        if (imem.rvalid)    state_nxt = S_ISSUE;
      end
      default: state_nxt = S_ISSUE;
    endcase
  end

  // Fetch request: a new fetch only when idle, or back-to-back as a response is consumed.
  always_comb begin
    imem.req  = 1'b0;
    imem.addr = pc_q;
    case (state)
      S_ISSUE: imem.req = !redirect_valid;
      S_WAIT: begin
        if (imem.rvalid && advance && !redirect_valid) begin
          imem.req  = 1'b1;
          imem.addr = pc_inc;
        end
      end
      default: ;
    endcase
    if (rst) imem.req = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_nxt;
  end

  // NOTE: the buffer payload is not reset; S_HOLD alone marks it as occupied.
  always_ff @(posedge clk) begin
    if (buf_load) begin
      buf_pc    <= pc_q;
      buf_instr <= imem.rdata;
    end
  end

  // Flush beats stall; a write-enabled cycle without a delivery inserts a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_valid <= 1'b0;
      if_id_pc    <= 32'h0;
      if_id_instr <= NOP_INSTR;
    end else if (redirect_valid) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
    end else if (!if_id_write) begin
      if_id_valid <= if_id_valid;
    end else if (deliver) begin
      if_id_valid <= 1'b1;
      if_id_pc    <= dlv_pc;
      if_id_instr <= dlv_instr;
    end else begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
    end
  end

endmodule
